// File: rtl/axi_addr_ch_rx_mux.sv
// N-channel AXI address receiver: one FIFO per channel, round-robin merge
// into a single registered valid/ready output stream tagged with its channel.
// Ports: rx_clk/reset_; packed per-channel in_* beats with in_valid/in_ready;
// out_valid/out_ready with out_ch and beat fields; buf_level/buf_empty status.
module axi_addr_ch_rx_mux #(
  parameter int NUM_CH     = 2,
  parameter int BUF_SZ     = 16,
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 8,
  parameter int USER_WIDTH = 2,
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int LVL_W = $clog2(BUF_SZ) + 1
) (
  input  logic                           rx_clk,
  input  logic                           reset_,
  input  logic [NUM_CH*ID_WIDTH-1:0]     in_id,
  input  logic [NUM_CH*ADDR_WIDTH-1:0]   in_addr,
  input  logic [NUM_CH*8-1:0]            in_len,
  input  logic [NUM_CH*3-1:0]            in_size,
  input  logic [NUM_CH*2-1:0]            in_burst,
  input  logic [NUM_CH*3-1:0]            in_prot,
  input  logic [NUM_CH*4-1:0]            in_cache,
  input  logic [NUM_CH*USER_WIDTH-1:0]   in_user,
  input  logic [NUM_CH-1:0]              in_lock,
  input  logic [NUM_CH-1:0]              in_valid,
  output logic [NUM_CH-1:0]              in_ready,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [CH_W-1:0]                out_ch,
  output logic [ID_WIDTH-1:0]            out_id,
  output logic [ADDR_WIDTH-1:0]          out_addr,
  output logic [7:0]                     out_len,
  output logic [2:0]                     out_size,
  output logic [1:0]                     out_burst,
  output logic [2:0]                     out_prot,
  output logic [3:0]                     out_cache,
  output logic [USER_WIDTH-1:0]          out_user,
  output logic                           out_lock,
  output logic [NUM_CH*LVL_W-1:0]        buf_level,
  output logic [NUM_CH-1:0]              buf_empty
);

  localparam int PTR_W = $clog2(BUF_SZ);
  localparam int ID_LO = 21;
  localparam int AD_LO = ID_LO + ID_WIDTH;
  localparam int US_LO = AD_LO + ADDR_WIDTH;
  localparam int EW    = US_LO + USER_WIDTH;

  logic [EW-1:0] mem [NUM_CH][BUF_SZ];

  logic [NUM_CH-1:0][PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [NUM_CH-1:0][PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [NUM_CH-1:0][LVL_W-1:0] level_q, level_d;
  logic [CH_W-1:0]              rr_ptr_q, rr_ptr_d;
  logic                         out_valid_q, out_valid_d;
  logic [CH_W-1:0]              out_ch_q, out_ch_d;
  logic [EW-1:0]                out_ent_q, out_ent_d;

  logic [NUM_CH-1:0][EW-1:0] in_ent;
  logic [NUM_CH-1:0]         full;
  logic [NUM_CH-1:0]         empty;
  logic [NUM_CH-1:0]         push;
  logic [NUM_CH-1:0]         pop;
  logic                      load;
  logic                      found;
  logic [CH_W-1:0]           gnt;
  logic [EW-1:0]             head;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      in_ent[i] = {in_user[i*USER_WIDTH +: USER_WIDTH],
                   in_addr[i*ADDR_WIDTH +: ADDR_WIDTH],
                   in_id[i*ID_WIDTH +: ID_WIDTH],
                   in_lock[i],
                   in_cache[i*4 +: 4],
                   in_prot[i*3 +: 3],
                   in_burst[i*2 +: 2],
                   in_size[i*3 +: 3],
                   in_len[i*8 +: 8]};
    end
  end

  // Full refuses writes even if the same FIFO pops this cycle.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      full[i]  = (level_q[i] == LVL_W'(BUF_SZ));
      empty[i] = (level_q[i] == '0);
      push[i]  = in_valid[i] & ~full[i];
    end
  end

  assign load = ~out_valid_q | out_ready;

  // Round-robin: first non-empty channel at or after rr_ptr, wrapping.
  always_comb begin
    int idx;
    idx   = 0;
    found = 1'b0;
    gnt   = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!found && !empty[idx]) begin
        found = 1'b1;
        gnt   = CH_W'(idx);
      end
    end
  end

  assign head = mem[gnt][rd_ptr_q[gnt]];

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      pop[i] = load & found & (gnt == CH_W'(i));
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      wr_ptr_d[i] = wr_ptr_q[i] + PTR_W'(push[i]);
      rd_ptr_d[i] = rd_ptr_q[i] + PTR_W'(pop[i]);
      level_d[i]  = level_q[i];
      if (push[i] && !pop[i]) begin
        level_d[i] = level_q[i] + LVL_W'(1);
      end else if (pop[i] && !push[i]) begin
        level_d[i] = level_q[i] - LVL_W'(1);
      end
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_ch_d    = out_ch_q;
    out_ent_d   = out_ent_q;
    rr_ptr_d    = rr_ptr_q;
    if (load) begin
      out_valid_d = found;
      if (found) begin
        out_ch_d  = gnt;
        out_ent_d = head;
        if (int'(gnt) == NUM_CH - 1) begin
          rr_ptr_d = '0;
        end else begin
          rr_ptr_d = gnt + CH_W'(1);
        end
      end
    end
  end

  // Storage carries no reset; pointers and levels define validity.
  always_ff @(posedge rx_clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (push[i]) mem[i][wr_ptr_q[i]] <= in_ent[i];
    end
  end

  always_ff @(posedge rx_clk or negedge reset_) begin
    if (!reset_) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      rr_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      out_ent_q   <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      rr_ptr_q    <= rr_ptr_d;
      out_valid_q <= out_valid_d;
      out_ch_q    <= out_ch_d;
      out_ent_q   <= out_ent_d;
    end
  end

  assign in_ready  = ~full;
  assign buf_level = level_q;
  assign buf_empty = empty;
  assign out_valid = out_valid_q;
  assign out_ch    = out_ch_q;
  assign out_len   = out_ent_q[7:0];
  assign out_size  = out_ent_q[10:8];
  assign out_burst = out_ent_q[12:11];
  assign out_prot  = out_ent_q[15:13];
  assign out_cache = out_ent_q[19:16];
  assign out_lock  = out_ent_q[20];
  assign out_id    = out_ent_q[ID_LO +: ID_WIDTH];
  assign out_addr  = out_ent_q[AD_LO +: ADDR_WIDTH];
  assign out_user  = out_ent_q[US_LO +: USER_WIDTH];

endmodule

// File: tb/tb_axi_addr_ch_rx_mux.sv
// Randomised bench for axi_addr_ch_rx_mux with a queue-based reference model
// and directed literal checks for latency, fill, fairness, wrap and reset.
module tb_axi_addr_ch_rx_mux;

  localparam int NC = 2;
  localparam int BS = 4;
  localparam int AW = 32;
  localparam int IW = 8;
  localparam int UW = 2;
  localparam int CW = 1;
  localparam int LW = 3;

  typedef struct packed {
    logic [CW-1:0] ch;
    logic [IW-1:0] id;
    logic [AW-1:0] addr;
    logic [7:0]    len;
    logic [2:0]    size;
    logic [1:0]    burst;
    logic [2:0]    prot;
    logic [3:0]    cache;
    logic [UW-1:0] user;
    logic          lock;
  } beat_t;

  logic rx_clk = 1'b0;
  logic reset_ = 1'b0;
  logic [NC*IW-1:0] in_id;
  logic [NC*AW-1:0] in_addr;
  logic [NC*8-1:0]  in_len;
  logic [NC*3-1:0]  in_size;
  logic [NC*2-1:0]  in_burst;
  logic [NC*3-1:0]  in_prot;
  logic [NC*4-1:0]  in_cache;
  logic [NC*UW-1:0] in_user;
  logic [NC-1:0]    in_lock;
  logic [NC-1:0]    in_valid = '0;
  logic [NC-1:0]    in_ready;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [CW-1:0]    out_ch;
  logic [IW-1:0]    out_id;
  logic [AW-1:0]    out_addr;
  logic [7:0]       out_len;
  logic [2:0]       out_size;
  logic [1:0]       out_burst;
  logic [2:0]       out_prot;
  logic [3:0]       out_cache;
  logic [UW-1:0]    out_user;
  logic             out_lock;
  logic [NC*LW-1:0] buf_level;
  logic [NC-1:0]    buf_empty;

  beat_t drv [NC];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 rx_clk = ~rx_clk;

  always_comb begin
    for (int i = 0; i < NC; i++) begin
      in_id[i*IW +: IW]   = drv[i].id;
      in_addr[i*AW +: AW] = drv[i].addr;
      in_len[i*8 +: 8]    = drv[i].len;
      in_size[i*3 +: 3]   = drv[i].size;
      in_burst[i*2 +: 2]  = drv[i].burst;
      in_prot[i*3 +: 3]   = drv[i].prot;
      in_cache[i*4 +: 4]  = drv[i].cache;
      in_user[i*UW +: UW] = drv[i].user;
      in_lock[i]          = drv[i].lock;
    end
  end

  axi_addr_ch_rx_mux #(
    .NUM_CH(NC), .BUF_SZ(BS), .ADDR_WIDTH(AW),
    .ID_WIDTH(IW), .USER_WIDTH(UW)
  ) dut (
    .rx_clk(rx_clk), .reset_(reset_),
    .in_id(in_id), .in_addr(in_addr), .in_len(in_len),
    .in_size(in_size), .in_burst(in_burst), .in_prot(in_prot),
    .in_cache(in_cache), .in_user(in_user), .in_lock(in_lock),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch),
    .out_id(out_id), .out_addr(out_addr), .out_len(out_len),
    .out_size(out_size), .out_burst(out_burst), .out_prot(out_prot),
    .out_cache(out_cache), .out_user(out_user), .out_lock(out_lock),
    .buf_level(buf_level), .buf_empty(buf_empty)
  );

  // Reference: queued beats per channel plus one held output beat.
  beat_t q [NC][$];
  beat_t held;
  bit    held_v;
  int    rr;

  always @(posedge rx_clk or negedge reset_) begin : model
    int sz [NC];
    int c;
    bit got;
    beat_t b;
    if (!reset_) begin
      for (int i = 0; i < NC; i++) q[i].delete();
      held   = '0;
      held_v = 1'b0;
      rr     = 0;
    end else begin
      for (int i = 0; i < NC; i++) sz[i] = q[i].size();
      if (!held_v || out_ready) begin
        got = 1'b0;
        for (int k = 0; k < NC; k++) begin
          c = (rr + k) % NC;
          if (!got && sz[c] > 0) begin
            held = q[c].pop_front();
            rr   = (c + 1) % NC;
            got  = 1'b1;
          end
        end
        held_v = got;
      end
      for (int i = 0; i < NC; i++) begin
        if (in_valid[i] && sz[i] < BS) begin
          b    = drv[i];
          b.ch = CW'(i);
          q[i].push_back(b);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic beat_t dut_beat();
    return {out_ch, out_id, out_addr, out_len, out_size,
            out_burst, out_prot, out_cache, out_user, out_lock};
  endfunction

  always @(negedge rx_clk) begin : cmp
    logic [NC-1:0] er, ee;
    logic [NC*LW-1:0] el;
    for (int i = 0; i < NC; i++) begin
      er[i] = q[i].size() < BS;
      ee[i] = q[i].size() == 0;
      el[i*LW +: LW] = LW'(q[i].size());
    end
    chk("out_valid", 64'(out_valid), 64'(held_v));
    chk("out_beat", 64'(dut_beat()), 64'(held));
    chk("in_ready", 64'(in_ready), 64'(er));
    chk("buf_level", 64'(buf_level), 64'(el));
    chk("buf_empty", 64'(buf_empty), 64'(ee));
  end

  // One clock; addresses advance on each accepted beat.
  task automatic step();
    logic [NC-1:0] rdy;
    rdy = in_ready;
    @(posedge rx_clk);
    #1;
    for (int i = 0; i < NC; i++) begin
      if (in_valid[i] && rdy[i]) drv[i].addr = drv[i].addr + 32'd4;
    end
  endtask

  task automatic do_reset();
    in_valid  = '0;
    out_ready = 1'b0;
    for (int i = 0; i < NC; i++) drv[i] = '0;
    reset_ = 1'b0;
    repeat (2) @(posedge rx_clk);
    #1;
    reset_ = 1'b1;
  endtask

  task automatic randomize_fields(input int i);
    drv[i].id    = IW'($urandom);
    drv[i].len   = 8'($urandom);
    drv[i].size  = 3'($urandom);
    drv[i].burst = 2'($urandom);
    drv[i].prot  = 3'($urandom);
    drv[i].cache = 4'($urandom);
    drv[i].user  = UW'($urandom);
    drv[i].lock  = 1'($urandom);
  endtask

  task automatic drain();
    in_valid  = '0;
    out_ready = 1'b1;
    for (int t = 0; t < 40 && !(buf_empty == '1 && !out_valid); t++) step();
    chk("drain_done", 64'({buf_empty, out_valid}), 64'({2'b11, 1'b0}));
  endtask

  logic [AW-1:0] exp_addr [5];
  logic [CW-1:0] exp_ch [5];
  int acc;

  initial begin
    for (int i = 0; i < NC; i++) drv[i] = '0;
    #1;
    chk("reset_valid", 64'(out_valid), 64'd0);
    chk("reset_empty", 64'(buf_empty), 64'd3);
    do_reset();

    // Single push on ch1, visible after the following edge.
    drv[1].addr = 32'h1000;
    drv[1].id   = 8'h5;
    drv[1].len  = 8'd3;
    in_valid    = 2'b10;
    step();
    in_valid = '0;
    step();
    chk("t1_valid", 64'(out_valid), 64'd1);
    chk("t1_ch", 64'(out_ch), 64'd1);
    chk("t1_addr", 64'(out_addr), 64'h1000);
    chk("t1_id", 64'(out_id), 64'h5);
    chk("t1_len", 64'(out_len), 64'd3);
    chk("t1_level1", 64'(buf_level[LW +: LW]), 64'd0);

    // Fill ch0 with the output stalled.
    do_reset();
    drv[0].addr = 32'h2000;
    in_valid    = 2'b01;
    repeat (6) step();
    chk("t2_level0", 64'(buf_level[0 +: LW]), 64'd4);
    chk("t2_ready0", 64'(in_ready[0]), 64'd0);
    chk("t2_head", 64'(out_addr), 64'h2000);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("t2_free", 64'(in_ready[0]), 64'd1);
    chk("t2_next", 64'(out_addr), 64'h2004);
    drain();

    // Fairness with both channels streaming.
    do_reset();
    drv[0].addr = 32'h0;
    drv[1].addr = 32'h100;
    in_valid    = 2'b11;
    out_ready   = 1'b1;
    exp_ch   = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    exp_addr = '{32'h0, 32'h100, 32'h4, 32'h104, 32'h8};
    step();
    for (int k = 0; k < 5; k++) begin
      step();
      chk("t3_ch", 64'(out_ch), 64'(exp_ch[k]));
      chk("t3_addr", 64'(out_addr), 64'(exp_addr[k]));
    end
    drain();

    // Toggling backpressure with random traffic on both channels.
    for (int t = 0; t < 80; t++) begin
      in_valid  = NC'($urandom);
      out_ready = t[0];
      for (int i = 0; i < NC; i++) randomize_fields(i);
      step();
    end
    drain();

    // Pointer wrap through a single channel.
    do_reset();
    drv[0].addr = 32'h3000;
    acc = 0;
    for (int t = 0; t < 200 && acc < 3*BS+1; t++) begin
      in_valid  = 2'b01;
      out_ready = ($urandom_range(3) != 0);
      randomize_fields(0);
      if (in_ready[0]) acc++;
      step();
    end
    chk("t5_count", 64'(acc), 64'(3*BS+1));
    drain();
    chk("t5_last", 64'(out_addr), 64'(32'h3000 + 4*(3*BS)));

    // Long random soak.
    for (int t = 0; t < 600; t++) begin
      in_valid  = NC'($urandom);
      out_ready = ($urandom_range(2) != 0);
      for (int i = 0; i < NC; i++) randomize_fields(i);
      step();
    end
    drain();

    // Asynchronous reset with traffic held and queued.
    do_reset();
    drv[0].addr = 32'h4000;
    in_valid    = 2'b01;
    repeat (4) step();
    in_valid = '0;
    chk("t6_pre_level", 64'(buf_level[0 +: LW]), 64'd3);
    chk("t6_pre_valid", 64'(out_valid), 64'd1);
    #2;
    reset_ = 1'b0;
    #1;
    chk("t6_valid", 64'(out_valid), 64'd0);
    chk("t6_addr", 64'(out_addr), 64'd0);
    chk("t6_ch", 64'(out_ch), 64'd0);
    chk("t6_level", 64'(buf_level), 64'd0);
    chk("t6_empty", 64'(buf_empty), 64'd3);
    @(posedge rx_clk);
    #1;
    reset_      = 1'b1;
    drv[0].addr = 32'h5000;
    drv[1].addr = 32'h6000;
    in_valid    = 2'b11;
    out_ready   = 1'b1;
    step();
    in_valid = '0;
    step();
    chk("t6_first_ch", 64'(out_ch), 64'd0);
    chk("t6_first_addr", 64'(out_addr), 64'h5000);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
